graph_mem_arbiter: RTL

//  Shares the two-port graph RAM (registered q, 1-cycle read) between NUM_REQ requesters (host loader, Dijkstra engine, debug).
//  Up to two grants per cycle: first winner to port A, second to port B; round-robin fairness.

---
 rtl/graph_mem_arbiter_pkg.sv | 14 +
 rtl/graph_mem_arbiter_rr_pick.sv | 25 ++
 rtl/graph_mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/graph_mem_arbiter_pkg.sv
// Shared defaults and types for the graph RAM arbiter slice.
// Owner index is sized for the largest supported requester count.
package graph_mem_pkg;
    localparam int unsigned GM_NUM_REQ    = 4;
    localparam int unsigned GM_DATA_WIDTH = 16;
    localparam int unsigned GM_ADDR_WIDTH = 5;
    localparam int unsigned GM_MAX_REQ    = 8;
    localparam int unsigned OWN_IDX_W     = $clog2(GM_MAX_REQ);

    typedef struct packed {
        logic                 vld;
        logic [OWN_IDX_W-1:0] idx;
    } port_own_t;
endpackage

// File: rtl/graph_mem_arbiter_rr_pick.sv
// Round-robin picker: first set bit of vec at or after start, wrapping.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int unsigned IW = $clog2(N);

    always_comb begin
        int unsigned pos;
        pos   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(start) + k) % N;
            if (!found && vec[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end
endmodule

// File: rtl/graph_mem_arbiter.sv
// Two-port graph RAM arbiter: up to two round-robin grants per cycle,
// cross-port hazard blocking, and 1-cycle read return to the owner.
module graph_mem_arbiter
    import graph_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = GM_NUM_REQ,
    parameter int unsigned DATA_WIDTH = GM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = GM_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr_a,
    output logic [DATA_WIDTH-1:0]         mem_data_a,
    output logic                          mem_we_a,
    input  logic [DATA_WIDTH-1:0]         mem_q_a,
    output logic [ADDR_WIDTH-1:0]         mem_addr_b,
    output logic [DATA_WIDTH-1:0]         mem_data_b,
    output logic                          mem_we_b,
    input  logic [DATA_WIDTH-1:0]         mem_q_b
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    port_own_t             own_a_q, own_a_d, own_b_q, own_b_d;
    logic                  a_found, b_found;
    logic [IW-1:0]         a_idx, b_idx;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_we;
    logic [NUM_REQ-1:0]    a_onehot, conflict_mask, b_vec;

    rr_pick #(.N(NUM_REQ)) u_pick_a (
        .vec   (req),
        .start (rr_ptr_q),
        .found (a_found),
        .idx   (a_idx)
    );

    // B scans from the same start; masking A leaves the first requester after A.
    always_comb begin
        a_addr        = req_addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH];
        a_we          = req_we[a_idx];
        a_onehot      = '0;
        conflict_mask = '0;
        if (a_found) begin
            a_onehot[a_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            conflict_mask[i] = a_found
                && (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == a_addr)
                && (req_we[i] || a_we);
        end
        b_vec = req & ~a_onehot & ~conflict_mask;
    end

    rr_pick #(.N(NUM_REQ)) u_pick_b (
        .vec   (b_vec),
        .start (rr_ptr_q),
        .found (b_found),
        .idx   (b_idx)
    );

    always_comb begin
        gnt        = '0;
        mem_addr_a = '0;
        mem_data_a = '0;
        mem_we_a   = 1'b0;
        mem_addr_b = '0;
        mem_data_b = '0;
        mem_we_b   = 1'b0;
        own_a_d    = '0;
        own_b_d    = '0;
        rr_ptr_d   = rr_ptr_q;
        if (rst_n) begin
            if (a_found) begin
                gnt[a_idx]  = 1'b1;
                mem_addr_a  = a_addr;
                mem_data_a  = req_wdata[a_idx*DATA_WIDTH +: DATA_WIDTH];
                mem_we_a    = a_we;
                own_a_d.vld = !a_we;
                own_a_d.idx = OWN_IDX_W'(a_idx);
                rr_ptr_d    = (a_idx == IW'(NUM_REQ-1)) ? '0 : a_idx + 1'b1;
            end
            if (b_found) begin
                gnt[b_idx]  = 1'b1;
                mem_addr_b  = req_addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data_b  = req_wdata[b_idx*DATA_WIDTH +: DATA_WIDTH];
                mem_we_b    = req_we[b_idx];
                own_b_d.vld = !req_we[b_idx];
                own_b_d.idx = OWN_IDX_W'(b_idx);
                rr_ptr_d    = (b_idx == IW'(NUM_REQ-1)) ? '0 : b_idx + 1'b1;
            end
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (own_a_q.vld && own_a_q.idx == OWN_IDX_W'(i)) begin
                rvalid[i]                       = 1'b1;
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_q_a;
            end
            if (own_b_q.vld && own_b_q.idx == OWN_IDX_W'(i)) begin
                rvalid[i]                       = 1'b1;
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_q_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            own_a_q  <= '0;
            own_b_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            own_a_q  <= own_a_d;
            own_b_q  <= own_b_d;
        end
    end
endmodule
